prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial PRBS receiver/checker. It is the response end of the random single-bit stimulus used to exercise our sequential cells.
- Consumes a 1-bit stream sampled from a DUT output, such as a DFF Q, and self-synchronises a local LFSR to it.
- Declares lock, then counts bit errors and drops lock on excessive error density.
- Used on-chip for BIST and in benches as a reusable synthesizable checker.

Parameters:
- N, 7: LFSR length in bits; 3..31.
- TAP_A, 7: first feedback tap, 1-based index into the LFSR.
- TAP_B, 6: second feedback tap, 1-based index; default polynomial is x^7+x^6+1.
- LOCK_CNT, 16: consecutive matching bits required to declare lock; at least 1.
- WINDOW, 64: error-density window length, in valid bits.
- LOSS_ERRS, 8: errors within one window that force loss of lock. LOSS_ERRS > WINDOW disables loss of lock.
- ERR_W, 16: width of the error counter.

Ports:
- clk, input, 1: rising-edge clock, the only clock.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- din_valid, input, 1: din is sampled only on cycles where this is 1.
- din, input, 1: received serial bit.
- clear_cnt, input, 1: synchronous clear of err_count.
- locked, output, 1: checker is synchronised to the stream.
- err_pulse, output, 1: one-cycle pulse per detected error while locked.
- err_count, output, ERR_W: saturating error total.

Behaviour:
- reset low: asynchronously force the following; all hold until reset returns high.
  - state = HUNT
  - lfsr = 0, fill_cnt = 0, match_cnt = 0
  - win_bits = 0, win_errs = 0
  - locked = 0, err_pulse = 0, err_count = 0
- All state advances only on clk edges with din_valid = 1. On cycles with din_valid = 0:
  - no state change
  - err_pulse = 0
- Expected bit: e = lfsr[TAP_A-1] ^ lfsr[TAP_B-1].
- HUNT state:
  - lfsr <= {lfsr[N-2:0], din}, i.e. the LFSR is loaded from the line.
  - While fill_cnt < N: fill_cnt increments; no comparison is made.
  - Once filled: if din == e and lfsr != 0, match_cnt increments; otherwise match_cnt <= 0.
  - When match_cnt reaches LOCK_CNT: state <= LOCKED, locked <= 1.
  - Clean stream: locked rises the cycle after valid bit number N+LOCK_CNT (23 with defaults).
- LOCKED state:
  - lfsr <= {lfsr[N-2:0], e}; the LFSR free-runs and is never reloaded from the line.
  - Mismatch (din != e):
    - err_pulse <= 1 for exactly one cycle
    - err_count increments, saturating at 2^ERR_W - 1
    - win_errs increments
  - Window: win_bits counts 0..WINDOW-1. On the valid bit that completes the window, win_bits and win_errs return to 0, and that bit's error is counted in the closing window.
  - When win_errs reaches LOSS_ERRS (the error bit included):
    - state <= HUNT, locked <= 0
    - fill_cnt, match_cnt, lfsr, win_bits, win_errs all <= 0
    - err_count is retained
  - Loss takes priority over window rollover on the same bit.
- Errors are never counted in HUNT; err_pulse is always 0 in HUNT.
- clear_cnt = 1: err_count <= 0. If clear_cnt coincides with an increment, clear wins and the result is 0. clear_cnt does not affect lock state.
- All outputs are registered, with 1-cycle latency from the sampled bit.
- Reset asserted mid-lock: outputs drop immediately, without waiting for a clock edge.

Decomposition:
- Package prbs_pkg holds:
  - state enum {HUNT, LOCKED}
  - PRBS7/PRBS15/PRBS23/PRBS31 tap constants
  - default LOCK_CNT, WINDOW and LOSS_ERRS constants
- One sub-module, prbs_lfsr: combinational next-state and expected-bit function, parameterised by N, TAP_A and TAP_B. It is shared with the future prbs_gen transmitter so both ends use an identical polynomial.

Test Plan:
1. Reset, then clean PRBS7 from seed 7'h7F with din_valid=1 every cycle -> locked=1 the cycle after valid bit 23; err_count=0 after 1000 bits.
2. While locked, invert one bit -> err_pulse high for exactly 1 cycle, err_count=1, locked stays 1.
3. While locked, invert 8 bits within 64 -> locked=0 the cycle after the 8th error, err_count=8. Resume a clean stream -> relock 23 valid bits later.
4. Repeat scenario 1 with din_valid randomly 50% -> lock after exactly 23 valid bits, not 23 cycles; no state change on invalid cycles.
5. ERR_W=4, LOSS_ERRS=65, 20 inverted bits while locked -> err_count saturates at 15, locked stays 1. Then clear_cnt coincident with an error -> err_count=0.
6. Reset driven low mid-lock between clock edges -> locked, err_pulse and err_count drop to 0 asynchronously. After release, HUNT reacquires in 23 valid bits.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types and constants for the PRBS checker (and the
// matching prbs_gen transmitter).
//   state_t          : checker FSM state encoding
//   PRBSx_TAP_A/B    : 1-based feedback taps for the standard polynomials
//   DEF_*            : default lock / window / loss thresholds
//   cnt_width()      : bits needed to hold the range 0..max_val
package prbs_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int PRBS7_TAP_A  = 7;
    localparam int PRBS7_TAP_B  = 6;
    localparam int PRBS15_TAP_A = 15;
    localparam int PRBS15_TAP_B = 14;
    localparam int PRBS23_TAP_A = 23;
    localparam int PRBS23_TAP_B = 18;
    localparam int PRBS31_TAP_A = 31;
    localparam int PRBS31_TAP_B = 28;

    localparam int DEF_LOCK_CNT  = 16;
    localparam int DEF_WINDOW    = 64;
    localparam int DEF_LOSS_ERRS = 8;

    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// prbs_lfsr: combinational Fibonacci LFSR step, shared by the checker and the
// transmitter so both ends always agree on the polynomial.
//   lfsr       : current register contents, bit 0 is the newest bit
//   shift_in   : bit to shift in when use_line is set
//   use_line   : 1 = load from the line, 0 = free-run on own feedback
//   expected   : feedback bit, i.e. the next bit the sequence predicts
//   lfsr_next  : register contents after one step
module prbs_lfsr
    import prbs_pkg::*;
#(
    parameter int N     = 7,
    parameter int TAP_A = PRBS7_TAP_A,
    parameter int TAP_B = PRBS7_TAP_B
) (
    input  logic [N-1:0] lfsr,
    input  logic         shift_in,
    input  logic         use_line,
    output logic         expected,
    output logic [N-1:0] lfsr_next
);

    assign expected  = lfsr[TAP_A-1] ^ lfsr[TAP_B-1];
    assign lfsr_next = {lfsr[N-2:0], (use_line ? shift_in : expected)};

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS checker.
//   clk        : rising-edge clock
//   reset      : asynchronous reset, active low
//   din_valid  : din is consumed only when high
//   din        : received serial bit
//   clear_cnt  : synchronous clear of err_count
//   locked     : local LFSR is synchronised to the stream
//   err_pulse  : one-cycle pulse per bit error while locked
//   err_count  : saturating error total
//
// state  | meaning
// HUNT   | LFSR loaded from the line; counting consecutive predicted bits
// LOCKED | LFSR free-runs; mismatches counted and error density monitored
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N         = 7,
    parameter int TAP_A     = PRBS7_TAP_A,
    parameter int TAP_B     = PRBS7_TAP_B,
    parameter int LOCK_CNT  = DEF_LOCK_CNT,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int LOSS_ERRS = DEF_LOSS_ERRS,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int FILL_W  = cnt_width(N);
    localparam int MATCH_W = cnt_width(LOCK_CNT);
    localparam int WIN_W   = cnt_width(WINDOW);

    // A window can never hold more than WINDOW errors, so a larger
    // threshold simply disables loss of lock.
    localparam bit LOSS_EN = (LOSS_ERRS <= WINDOW);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(N);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0]   LOSS_LIM   = LOSS_EN ? WIN_W'(LOSS_ERRS) : '0;

    state_t               state;
    logic [N-1:0]         lfsr;
    logic [N-1:0]         lfsr_next;
    logic [FILL_W-1:0]    fill_cnt;
    logic [MATCH_W-1:0]   match_cnt;
    logic [MATCH_W-1:0]   match_inc;
    logic [WIN_W-1:0]     win_bits;
    logic [WIN_W-1:0]     win_errs;
    logic [WIN_W-1:0]     win_errs_inc;
    logic                 expected;
    logic                 mismatch;
    logic                 loss;
    logic                 err_inc;

    prbs_lfsr #(
        .N     (N),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_lfsr (
        .lfsr      (lfsr),
        .shift_in  (din),
        .use_line  (state == HUNT),
        .expected  (expected),
        .lfsr_next (lfsr_next)
    );

    assign mismatch     = din ^ expected;
    assign match_inc    = match_cnt + MATCH_W'(1);
    assign win_errs_inc = win_errs + WIN_W'(1);
    assign loss         = LOSS_EN && (win_errs_inc == LOSS_LIM);
    assign err_inc      = din_valid && (state == LOCKED) && mismatch && !(&err_count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            lfsr      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (din_valid) begin
                lfsr <= lfsr_next;
                case (state)
                    HUNT: begin
                        if (fill_cnt != FILL_FULL) begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end else if (!mismatch && (lfsr != '0)) begin
                            if (match_inc == MATCH_LOCK) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_inc;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        err_pulse <= mismatch;
                        // Loss is checked before rollover so an error that
                        // closes a window can still drop lock.
                        if (mismatch && loss) begin
                            state     <= HUNT;
                            locked    <= 1'b0;
                            lfsr      <= '0;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            win_bits  <= '0;
                            win_errs  <= '0;
                        end else if (win_bits == WIN_LAST) begin
                            win_bits <= '0;
                            win_errs <= '0;
                        end else begin
                            win_bits <= win_bits + WIN_W'(1);
                            if (mismatch) win_errs <= win_errs_inc;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end

            if (clear_cnt) begin
                err_count <= '0;
            end else if (err_inc) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

    logic        clk;
    logic        reset;
    logic        din_valid;
    logic        din;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        locked_s;
    logic        err_pulse_s;
    logic [3:0]  err_count_s;

    int n_checks;
    int n_errors;
    int pulse_seen;
    logic [6:0] g;

    prbs_checker dut (
        .clk       (clk),
        .reset     (reset),
        .din_valid (din_valid),
        .din       (din),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    // Narrow counter with loss of lock disabled, for saturation tests.
    prbs_checker #(
        .ERR_W     (4),
        .LOSS_ERRS (65)
    ) dut_s (
        .clk       (clk),
        .reset     (reset),
        .din_valid (din_valid),
        .din       (din),
        .clear_cnt (clear_cnt),
        .locked    (locked_s),
        .err_pulse (err_pulse_s),
        .err_count (err_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; a valid bit is the next PRBS7 bit, optionally
    // inverted. Outputs are sampled 1 time unit after the edge.
    task automatic send(input logic v, input logic inv);
        logic b;
        if (v) begin
            b = g[6] ^ g[5];
            g = {g[5:0], b};
            din = b ^ inv;
        end else begin
            din = 1'($urandom_range(0, 1));
        end
        din_valid = v;
        @(posedge clk);
        #1;
        if (err_pulse) pulse_seen++;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        clear_cnt = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        g = 7'h7F;
    endtask

    initial begin
        int nvalid;
        logic v;
        n_checks   = 0;
        n_errors   = 0;
        pulse_seen = 0;
        reset      = 1'b0;
        din_valid  = 1'b0;
        din        = 1'b0;
        clear_cnt  = 1'b0;
        g          = 7'h7F;

        // 1: reset values, clean lock timing, 1000 clean bits
        @(negedge clk);
        @(negedge clk);
        check_val("rst_locked", locked, 0);
        check_val("rst_err_pulse", err_pulse, 0);
        check_val("rst_err_count", err_count, 0);
        do_reset();
        repeat (22) send(1'b1, 1'b0);
        check_val("s1_pre_lock", locked, 0);
        send(1'b1, 1'b0);
        check_val("s1_lock_bit23", locked, 1);
        pulse_seen = 0;
        repeat (977) send(1'b1, 1'b0);
        check_val("s1_errs_1000", err_count, 0);
        check_val("s1_still_locked", locked, 1);
        check_val("s1_no_pulse", pulse_seen, 0);

        // 2: single inverted bit
        send(1'b1, 1'b1);
        check_val("s2_pulse", err_pulse, 1);
        check_val("s2_count", err_count, 1);
        check_val("s2_locked", locked, 1);
        send(1'b1, 1'b0);
        check_val("s2_pulse_one_cycle", err_pulse, 0);
        send(1'b0, 1'b0);
        check_val("s2_count_hold", err_count, 1);

        // 3: 8 errors in one window drop lock, then relock
        do_reset();
        repeat (23) send(1'b1, 1'b0);
        check_val("s3_locked", locked, 1);
        repeat (5) send(1'b1, 1'b0);
        repeat (7) send(1'b1, 1'b1);
        check_val("s3_seven_locked", locked, 1);
        check_val("s3_seven_count", err_count, 7);
        send(1'b1, 1'b1);
        check_val("s3_loss", locked, 0);
        check_val("s3_loss_count", err_count, 8);
        check_val("s3_loss_pulse", err_pulse, 1);
        repeat (22) send(1'b1, 1'b0);
        check_val("s3_relock_pre", locked, 0);
        send(1'b1, 1'b0);
        check_val("s3_relock", locked, 1);
        check_val("s3_count_kept", err_count, 8);

        // 4: 50% din_valid, lock after 23 valid bits
        do_reset();
        nvalid = 0;
        for (int c = 0; c < 2000 && nvalid < 22; c++) begin
            v = 1'($urandom_range(0, 1));
            send(v, 1'b0);
            if (v) nvalid++;
        end
        check_val("s4_valid_budget", nvalid, 22);
        repeat (3) send(1'b0, 1'b0);
        check_val("s4_hold_invalid", locked, 0);
        send(1'b1, 1'b0);
        check_val("s4_lock_valid23", locked, 1);
        pulse_seen = 0;
        for (int c = 0; c < 60; c++) begin
            v = 1'($urandom_range(0, 1));
            send(v, 1'b0);
        end
        check_val("s4_errs", err_count, 0);
        check_val("s4_locked", locked, 1);
        check_val("s4_no_pulse", pulse_seen, 0);

        // 5: saturation at 15 with loss disabled, clear beats increment
        do_reset();
        repeat (23) send(1'b1, 1'b0);
        check_val("s5_locked", locked_s, 1);
        repeat (15) send(1'b1, 1'b1);
        check_val("s5_at_15", err_count_s, 15);
        send(1'b1, 1'b1);
        check_val("s5_sat_hold", err_count_s, 15);
        repeat (4) send(1'b1, 1'b1);
        check_val("s5_sat_20", err_count_s, 15);
        check_val("s5_still_locked", locked_s, 1);
        clear_cnt = 1'b1;
        send(1'b1, 1'b1);
        clear_cnt = 1'b0;
        check_val("s5_clear_wins", err_count_s, 0);
        check_val("s5_clear_pulse", err_pulse_s, 1);
        check_val("s5_clear_locked", locked_s, 1);

        // 6: asynchronous reset mid-lock, then reacquire
        do_reset();
        repeat (23) send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        check_val("s6_pre_pulse", err_pulse, 1);
        check_val("s6_pre_count", err_count, 1);
        #2;
        reset = 1'b0;
        #1;
        check_val("s6_async_locked", locked, 0);
        check_val("s6_async_pulse", err_pulse, 0);
        check_val("s6_async_count", err_count, 0);
        @(negedge clk);
        reset = 1'b1;
        g = 7'h7F;
        repeat (22) send(1'b1, 1'b0);
        check_val("s6_relock_pre", locked, 0);
        send(1'b1, 1'b0);
        check_val("s6_relock", locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
